// File: rtl/div_4bits.sv
// Restoring divider: 2*bits dividend / bits divisor, one quotient bit per clock.
// Latency 2*bits+1 cycles from the start edge to the done pulse, or 1 for B==0 when DIV_FAST_ZERO_EN is defined.
// No backpressure: start is ignored while busy and honoured in IDLE or DONE; results hold until the next done.
module div_4bits #(
  parameter int bits = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*bits-1:0]   A,
  input  logic [bits-1:0]     B,
  output logic                busy,
  output logic                done,
  output logic [2*bits-1:0]   Quotient_o,
  output logic [bits-1:0]     Remainder_o,
  output logic                div_zero_o
);

  localparam int cw = $clog2(2*bits) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [2*bits-1:0] dvd;
  logic [bits-1:0]   rem;
  logic [bits-1:0]   dsr;
  logic [cw-1:0]     cnt;
  logic              dz;

  logic [bits:0]     rem_sh;
  logic [bits+1:0]   trial;
  logic              qbit;
  logic [bits:0]     rem_nxt;
  logic [2*bits-1:0] dvd_nxt;
  logic              accept;
  logic              last_step;
  logic              fast_zero;

  // One restoring step. dvd is reused as the quotient shift register.
  // The restored remainder is always below B, so only bits of it are kept.
  always_comb begin
    rem_sh  = {rem, dvd[2*bits-1]};
    trial   = {1'b0, rem_sh} - {2'b00, dsr};
    qbit    = ~trial[bits+1];
    rem_nxt = qbit ? trial[bits:0] : rem_sh;
    dvd_nxt = {dvd[2*bits-2:0], qbit};
  end

  always_comb begin
    accept    = start && (state != RUN);
    last_step = (state == RUN) && (cnt == cw'(2*bits-1));
`ifdef DIV_FAST_ZERO_EN
    fast_zero = accept && (B == '0);
`else
    fast_zero = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = fast_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = fast_zero ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dvd         <= '0;
      rem         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      Quotient_o  <= '0;
      Remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else if (accept) begin
      dvd <= A;
      dsr <= B;
      rem <= '0;
      cnt <= '0;
      dz  <= (B == '0);
      // Same values the full restoring run produces for a zero divisor.
      if (fast_zero) begin
        Quotient_o  <= '1;
        Remainder_o <= A[bits-1:0];
        div_zero_o  <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd <= dvd_nxt;
      rem <= rem_nxt[bits-1:0];
      cnt <= cnt + cw'(1);
      if (last_step) begin
        Quotient_o  <= dvd_nxt;
        Remainder_o <= rem_nxt[bits-1:0];
        div_zero_o  <= dz;
      end
    end
  end

endmodule

// File: tb/tb_div_4bits.sv
// Scoreboard bench for div_4bits: driver pushes expected results, monitor pops on done.
module tb_div_4bits;

  localparam int BITS = 4;
  localparam int W    = 2*BITS;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   A = '0;
  logic [BITS-1:0] B = '0;
  logic           busy, done, div_zero_o;
  logic [W-1:0]   Quotient_o;
  logic [BITS-1:0] Remainder_o;

  div_4bits #(.bits(BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Quotient_o(Quotient_o),
    .Remainder_o(Remainder_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]    q;
    logic [BITS-1:0] r;
    logic            dz;
    int              due;
  } exp_t;

  exp_t            sb[$];
  int              chk = 0;
  int              err = 0;
  logic [W-1:0]    last_q = '0;
  logic [BITS-1:0] last_r = '0;
  logic            last_dz = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones and the dividend's low bits.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q  = W'((1 << W) - 1);
      e.r  = BITS'(a % (1 << BITS));
      e.dz = 1'b1;
    end else begin
      e.q  = W'(a / b);
      e.r  = BITS'(a % b);
      e.dz = 1'b0;
    end
    e.due = 0;
    return e;
  endfunction

  function automatic bit is_fast(input int b);
`ifdef DIV_FAST_ZERO_EN
    return (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic issue(input int a, input int b);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("issue_wait_busy", 32'(busy), 0);
    A = W'(a);
    B = BITS'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = BITS'($urandom);
    e = model(a, b);
    e.due = cyc + (is_fast(b) ? 0 : W);
    sb.push_back(e);
    if (is_fast(b)) check("accept_fast_done", 32'({busy, done}), 32'b01);
    else            check("accept_busy", 32'({busy, done}), 32'b10);
  endtask

  // Monitor: results only move on done, and each done matches the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (busy && done) check("busy_done_overlap", 32'({busy, done}), 32'b10);
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 0);
          end else begin
            e = sb.pop_front();
            check("quotient", 32'(Quotient_o), 32'(e.q));
            check("remainder", 32'(Remainder_o), 32'(e.r));
            check("div_zero", 32'(div_zero_o), 32'(e.dz));
            check("latency_cycle", 32'(cyc), 32'(e.due));
            last_q  = e.q;
            last_r  = e.r;
            last_dz = e.dz;
          end
        end else begin
          check("hold_outputs", 32'({Quotient_o, Remainder_o, div_zero_o}),
                32'({last_q, last_r, last_dz}));
          if (sb.size() > 0 && cyc > sb[0].due) begin
            check("missing_done", 32'(done), 1);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(Quotient_o), 0);
    check("rst_r", 32'(Remainder_o), 0);
    check("rst_dz", 32'(div_zero_o), 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases; consecutive issues land in the DONE cycle (back-to-back)
    issue(225, 15);
    issue(200, 7);
    issue(0, 5);
    issue(100, 0);
    issue(255, 1);

    // start mid-RUN is ignored
    issue(143, 11);
    repeat (3) @(negedge clk);
    A = 8'd9;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Reset in the middle of RUN aborts without a done pulse
    issue(77, 6);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_q", 32'(Quotient_o), 0);
    check("abort_r", 32'(Remainder_o), 0);
    check("abort_dz", 32'(div_zero_o), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);

    // Exhaustive nonzero divisors
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        issue(a, b);

    // Random operands including zero divisors, with occasional idle gaps
    for (int i = 0; i < 200; i++) begin
      issue(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)));
      if ($urandom_range(3, 0) == 0) repeat (int'($urandom_range(12, 1))) @(negedge clk);
    end

    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(sb.size()), 0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
